pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It generalises the team's 4-bit combinational rca_adder to WIDTH bits, split into STAGES carry-registered slices, with a per-stage valid/ready handshake. It is the arithmetic datapath element for streaming blocks that need throughput of one operation per clock at widths where a full ripple chain misses timing.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of STAGES.
STAGES, 2, pipeline depth; each stage adds one CHUNK = WIDTH/STAGES slice; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  stage 0 can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  1: compute a - b (a + ~b + 1); 0: compute a + b + cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
cout  output  1  carry-out (for sub: 1 = no borrow, i.e. a >= b unsigned)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous, active-high): every stage valid bit = 0; out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready = 1 when reset deasserts. Reset mid-operation discards all in-flight beats; no result is emitted for them.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Output payload is held stable while out_valid && !out_ready.
- Stage k (0..STAGES-1) registers:
  - vk
  - sum slices [0 .. (k+1)*CHUNK-1], already computed
  - carry out of slice k
  - the not-yet-added upper slices of a and effective b (b, or ~b when sub)
  - for the last stage only: the MSB carry-in, needed for ovf.
- Stage 0 adds slice 0 with carry = sub ? 1 : cin. Stage k adds slice k of the delayed operands with the registered carry from stage k-1.
- Per-stage flow control with bubble collapse:
  - Stage k advances when !vk, or stage k+1 advances (last stage: when out_ready).
  - in_ready = stage 0 advances. This is combinational from out_ready through the stage valid bits; there is no skid buffer.
- Latency: exactly STAGES cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Ordering: strictly in order; no beat is dropped or duplicated under any out_ready pattern.
- Bubbles: if the pipeline holds a gap while the output is stalled, upstream beats advance into the gap. With out_ready=0 the pipeline accepts exactly STAGES beats, then in_ready=0.
- Arithmetic: unsigned modulo 2^WIDTH on sum; {cout,sum} = a + b + cin (add) or a + ~b + 1 (sub). ovf is valid for both modes.
- Boundary: all-ones + cin=1 wraps sum to 0 with cout=1. Carry must propagate correctly across every slice boundary (e.g. 0x0F+0x01 in WIDTH=8, STAGES=2).
- STAGES=1: single registered full-width add, latency 1.
- Simultaneous out_ready rise and in_valid: both transfers occur in the same cycle; occupancy is unchanged.

Test Plan:
- Exhaustive sweep, WIDTH=4, STAGES=2: for i=0..511 drive {cin,b,a}=i, sub=0, out_ready=1 -> each result appears 2 cycles later in order with {cout,sum}=a+b+cin (e.g. a=15, b=15, cin=1 -> sum=15, cout=1). Scoreboard against a behavioural model.
- Cross-slice carry, WIDTH=8, STAGES=4: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0, latency 4. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1, cout=0.
- Subtract, WIDTH=8, STAGES=2: a=5, b=7, sub=1, cin=1 -> sum=0xFE, cout=0 (cin ignored). a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1.
- Backpressure, WIDTH=8, STAGES=4: out_ready=0, in_valid=1 with a=1..6 -> exactly 4 beats accepted, then in_ready=0. Release out_ready -> results 1+b..4+b emerge in order, then the remaining beats, none lost or duplicated. Repeat with random out_ready toggling over 1000 beats.
- Bubble collapse: beat, 2-cycle gap, beat with out_ready=0 -> both beats occupy the last two stages and in_ready stays 1 until 4 beats are held.
- Reset mid-stream: assert reset asynchronously (between clock edges) with 3 beats in flight -> out_valid, sum, cout, ovf go to 0 immediately. After release, no stale result appears and the next beat has latency STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices,
// one slice added per stage, with per-stage valid/ready and bubble collapse.
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : stg
         // AW: operand bits still pending on entry; SW: sum bits known on exit
         localparam int AW = WIDTH - gi * CHUNK;
         localparam int SW = (gi + 1) * CHUNK;

         logic          v_in;
         logic          c_in;
         logic          adv;
         logic [AW-1:0] a_in;
         logic [AW-1:0] b_in;
         logic [CHUNK:0] slice;
         logic [SW-1:0] sum_next;
         logic          v_reg;
         logic          c_reg;
         logic [SW-1:0] sum_reg;

         assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, c_in};

         if (gi == 0) begin : g_head
            assign v_in     = in_valid;
            assign a_in     = a;
            assign b_in     = sub ? ~b : b;
            assign c_in     = sub | cin;
            assign sum_next = slice[CHUNK-1:0];
            assign in_ready = adv;
         end else begin : g_body
            assign v_in     = stg[gi-1].v_reg;
            assign a_in     = stg[gi-1].g_fwd.a_reg;
            assign b_in     = stg[gi-1].g_fwd.b_reg;
            assign c_in     = stg[gi-1].c_reg;
            assign sum_next = {slice[CHUNK-1:0], stg[gi-1].sum_reg};
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v_reg   <= 1'b0;
               c_reg   <= 1'b0;
               sum_reg <= '0;
            end else if (adv) begin
               v_reg <= v_in;
               if (v_in) begin
                  c_reg   <= slice[CHUNK];
                  sum_reg <= sum_next;
               end
            end
         end

         if (gi == STAGES - 1) begin : g_tail
            logic cmsb_reg;

            assign adv = !v_reg || out_ready;

            // Carry into the MSB recovered from the MSB sum bit, for signed overflow
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  cmsb_reg <= 1'b0;
               end else if (adv && v_in) begin
                  cmsb_reg <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ slice[CHUNK-1];
               end
            end

            assign out_valid = v_reg;
            assign sum       = sum_reg;
            assign cout      = c_reg;
            assign ovf       = cmsb_reg ^ c_reg;
         end else begin : g_fwd
            logic [AW-CHUNK-1:0] a_reg;
            logic [AW-CHUNK-1:0] b_reg;

            assign adv = !v_reg || stg[gi+1].adv;

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  a_reg <= '0;
                  b_reg <= '0;
               end else if (adv && v_in) begin
                  a_reg <= a_in[AW-1:CHUNK];
                  b_reg <= b_in[AW-1:CHUNK];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=4): directed boundary
// beats, backpressure, bubble collapse, async reset, and a random scoreboard run.
module tb_pipelined_adder;

   localparam int W = 8;
   localparam int S = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;
   int   n_in    = 0;
   int   n_out   = 0;
   res_t q[$];

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain unsigned sum for {cout,sum}, signed-range test for ovf
   function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tcin, input logic tsub);
      res_t r;
      int   u;
      int   s;
      int   sa;
      int   sb;
      sa = $signed(ta);
      sb = $signed(tb);
      if (tsub) begin
         u = int'(ta) + ((2 ** W) - 1 - int'(tb)) + 1;
         s = sa - sb;
      end else begin
         u = int'(ta) + int'(tb) + int'(tcin);
         s = sa + sb + int'(tcin);
      end
      r.sum  = u[W-1:0];
      r.cout = (u >= 2 ** W);
      r.ovf  = (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, score outputs, record inputs
   task automatic tick();
      res_t e;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out", {31'b0, out_valid}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("sb_sum", {24'b0, sum}, {24'b0, e.sum});
            chk("sb_cout", {31'b0, cout}, {31'b0, e.cout});
            chk("sb_ovf", {31'b0, ovf}, {31'b0, e.ovf});
            n_out++;
            $display("out %0d: sum=%02h cout=%b ovf=%b", n_out, sum, cout, ovf);
         end
      end
      if (in_valid && in_ready) begin
         q.push_back(model(a, b, cin, sub));
         n_in++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int g;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      g = 0;
      while (q.size() > 0 && g < 50) begin
         tick();
         g++;
      end
      chk(tag, q.size(), 32'd0);
   endtask

   // Single beat into an empty pipe: checks latency and the literal expected result
   task automatic lat_beat(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input logic tsub,
                           input logic [W-1:0] es, input logic ec, input logic eo);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = ta; b = tb; cin = tcin; sub = tsub;
      #1 chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (lat < 20) begin
         #1;
         if (out_valid) break;
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, S);
      chk({tag, "_sum"}, {24'b0, sum}, {24'b0, es});
      chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
      chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int acc;
      int n0;
      int g;
      int out0;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum", {24'b0, sum}, 32'd0);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);

      // Directed boundary beats
      lat_beat("wrap",     8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      lat_beat("pos_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      lat_beat("sub_brw",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      lat_beat("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      lat_beat("nib_cry",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      lat_beat("all_ones", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

      // Backpressure: stalled output accepts exactly S beats
      out_ready = 1'b0;
      idx = 1;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1; a = W'(idx); b = 8'h10; cin = 1'b0; sub = 1'b0;
         n0 = n_in;
         tick();
         if (n_in != n0) idx++;
      end
      chk("bp_accepted", idx - 1, S);
      #1 chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      g = 0;
      while ((idx <= 6 || q.size() > 0) && g < 40) begin
         in_valid = (idx <= 6); a = W'(idx);
         n0 = n_in;
         tick();
         if (n_in != n0) idx++;
         g++;
      end
      chk("bp_all_sent", idx - 1, 6);
      chk("bp_drained", q.size(), 32'd0);

      // Bubble collapse: two beats with a gap settle at the tail while stalled
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'h21; b = 8'h03; cin = 1'b1; sub = 1'b0;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      in_valid = 1'b1; a = 8'h44; b = 8'h55; cin = 1'b0; sub = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #1 chk("bub_in_ready_two_held", {31'b0, in_ready}, 32'd1);
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; a = W'(8'h60 + c); b = 8'h0A; cin = 1'b0; sub = 1'b0;
         n0 = n_in;
         tick();
         if (n_in != n0) acc++;
      end
      chk("bub_more_accepted", acc, 2);
      #1 chk("bub_in_ready_full", {31'b0, in_ready}, 32'd0);
      drain("bub_drained");

      // Random traffic with toggling out_ready
      out0 = n_out;
      n0 = n_in;
      g = 0;
      while ((n_in - n0 < 1000 || q.size() > 0) && g < 20000) begin
         in_valid  = (n_in - n0 < 1000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a   = W'($urandom);
         b   = W'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         tick();
         g++;
      end
      chk("rand_in_count", n_in - n0, 1000);
      chk("rand_out_count", n_out - out0, 1000);
      chk("rand_drained", q.size(), 32'd0);

      // Asynchronous reset with three beats held
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; a = 8'h90; b = 8'h90; cin = 1'b0; sub = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      g = 0;
      while (g < 10) begin
         #1;
         if (out_valid) break;
         tick();
         g++;
      end
      chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_sum", {24'b0, sum}, 32'd0);
      chk("mid_rst_cout", {31'b0, cout}, 32'd0);
      chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (8) tick();
      #1 chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
      lat_beat("post_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
